if_id_ctrl: RTL and testbench

IF_ID_CTRL -- requirements
Module: if_id_ctrl

---
 rtl/if_id_ctrl.sv | 99 +++++++++
 tb/tb_if_id_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ctrl.sv
// ============================================================================
// if_id_ctrl: IF/ID pipeline register with jump, branch and stall redirect.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_ctrl #(
    parameter int          WIDTH   = 32,
    parameter logic [5:0]  JMP_OPC = 6'b000010,
    parameter logic [31:0] NOP     = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [31:0]      instr_in,
    input  logic             stall,
    input  logic             ex_branch_taken,
    input  logic [WIDTH-1:0] ex_branch_pc,
    output logic [WIDTH-1:0] jmp_pc,
    output logic             pc_selector,
    output logic [WIDTH-1:0] pc_out,
    output logic [31:0]      instr_out,
    output logic             valid_out,
    output logic             flush_ex,
    output logic             stalled,
    output logic [15:0]      redirect_cnt
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic             dj;
    logic             redirect;
    logic [WIDTH-1:0] jump_target;
    logic [27:0]      jump_low;

    assign dj       = valid_out && (instr_out[31:26] == JMP_OPC);
    // A decode jump only redirects once the stall has cleared; a branch always wins.
    assign redirect = ex_branch_taken || (dj && !stall);
    assign jump_low = {instr_out[25:0], 2'b00};
    assign stalled  = (state == HOLD);

    generate
        if (WIDTH > 28) begin : g_tgt_wide
            assign jump_target = {pc_out[WIDTH-1:28], jump_low};
        end else begin : g_tgt_narrow
            assign jump_target = jump_low[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        jmp_pc      = pc_in;
        pc_selector = 1'b0;
        flush_ex    = 1'b0;
        if (reset) begin
            if (ex_branch_taken) begin
                jmp_pc      = ex_branch_pc;
                pc_selector = 1'b1;
                flush_ex    = 1'b1;
            end else if (stall) begin
                pc_selector = 1'b1;
            end else if (dj) begin
                jmp_pc      = jump_target;
                pc_selector = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            pc_out       <= '0;
            instr_out    <= NOP;
            valid_out    <= 1'b0;
            redirect_cnt <= 16'h0000;
        end else begin
            state <= (stall && !ex_branch_taken) ? HOLD : RUN;
            if (redirect) begin
                // Bubble squashes the wrong-path fetch and clears dj for next cycle.
                pc_out    <= pc_in;
                instr_out <= NOP;
                valid_out <= 1'b0;
            end else if (!stall) begin
                pc_out    <= pc_in;
                instr_out <= instr_in;
                valid_out <= 1'b1;
            end
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'h0001;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_id_ctrl.sv
// ============================================================================
// tb_if_id_ctrl: directed self-checking bench for if_id_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        stall;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_pc;
    logic [31:0] jmp_pc;
    logic        pc_selector;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        flush_ex;
    logic        stalled;
    logic [15:0] redirect_cnt;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [31:0] ALU_A = 32'h2000_0001;
    localparam logic [31:0] ALU_B = 32'h2000_0002;
    localparam logic [31:0] JMP17 = 32'h0800_0017;
    localparam logic [31:0] JMP40 = 32'h0800_0040;

    if_id_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .stall          (stall),
        .ex_branch_taken(ex_branch_taken),
        .ex_branch_pc   (ex_branch_pc),
        .jmp_pc         (jmp_pc),
        .pc_selector    (pc_selector),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .valid_out      (valid_out),
        .flush_ex       (flush_ex),
        .stalled        (stalled),
        .redirect_cnt   (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_in = 32'h40; instr_in = JMP17;
        stall = 1'b1; ex_branch_taken = 1'b1; ex_branch_pc = 32'h100;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL rst_sel got %b want 0", pc_selector); end
        compared++; if (flush_ex !== 1'b0) begin mismatched++; $display("FAIL rst_flush got %b want 0", flush_ex); end
        tick(); tick();
        compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL rst_pc got %h want 0", pc_out); end
        compared++; if (instr_out !== 32'h0) begin mismatched++; $display("FAIL rst_instr got %h want 0", instr_out); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", valid_out); end
        compared++; if (stalled !== 1'b0) begin mismatched++; $display("FAIL rst_stalled got %b want 0", stalled); end
        compared++; if (redirect_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_cnt got %h want 0", redirect_cnt); end
        reset = 1'b1; pc_in = 32'h0; instr_in = ALU_A;
        stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_pc = 32'h0;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL rel_sel got %b want 0", pc_selector); end
        tick();
        compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL rel_pc got %h want 0", pc_out); end
        compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL rel_valid got %b want 1", valid_out); end
        compared++; if (redirect_cnt !== 16'h0) begin mismatched++; $display("FAIL rel_cnt got %h want 0", redirect_cnt); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            pc_in = 32'(i * 4); instr_in = ALU_B;
            #1;
            compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL seq_sel[%0d] got %b want 0", i, pc_selector); end
            compared++; if (jmp_pc !== 32'(i * 4)) begin mismatched++; $display("FAIL seq_jmp[%0d] got %h want %h", i, jmp_pc, i * 4); end
            tick();
            compared++; if (pc_out !== 32'(i * 4)) begin mismatched++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_out, i * 4); end
            compared++; if (instr_out !== ALU_B) begin mismatched++; $display("FAIL seq_instr[%0d] got %h want %h", i, instr_out, ALU_B); end
            compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL seq_valid[%0d] got %b want 1", i, valid_out); end
        end
    endtask

    task automatic test_jump();
        pc_in = 32'h10; instr_in = JMP17;
        tick();
        pc_in = 32'h14; instr_in = ALU_A;
        #1;
        compared++; if (pc_selector !== 1'b1) begin mismatched++; $display("FAIL dj_sel got %b want 1", pc_selector); end
        compared++; if (jmp_pc !== 32'h5C) begin mismatched++; $display("FAIL dj_target got %h want 5c", jmp_pc); end
        compared++; if (flush_ex !== 1'b0) begin mismatched++; $display("FAIL dj_flush got %b want 0", flush_ex); end
        tick();
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL dj_bubble_valid got %b want 0", valid_out); end
        compared++; if (instr_out !== 32'h0) begin mismatched++; $display("FAIL dj_bubble_instr got %h want 0", instr_out); end
        compared++; if (redirect_cnt !== 16'h1) begin mismatched++; $display("FAIL dj_cnt got %h want 1", redirect_cnt); end
        pc_in = 32'h5C; instr_in = ALU_B;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL dj_after_sel got %b want 0", pc_selector); end
        tick();
        compared++; if (pc_out !== 32'h5C) begin mismatched++; $display("FAIL dj_landed_pc got %h want 5c", pc_out); end
        compared++; if (redirect_cnt !== 16'h1) begin mismatched++; $display("FAIL dj_landed_cnt got %h want 1", redirect_cnt); end
    endtask

    task automatic test_stall();
        pc_in = 32'h20; instr_in = ALU_A; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++; if (pc_selector !== 1'b1) begin mismatched++; $display("FAIL st_sel[%0d] got %b want 1", i, pc_selector); end
            compared++; if (jmp_pc !== 32'h20) begin mismatched++; $display("FAIL st_jmp[%0d] got %h want 20", i, jmp_pc); end
            tick();
            compared++; if (stalled !== 1'b1) begin mismatched++; $display("FAIL st_stalled[%0d] got %b want 1", i, stalled); end
            compared++; if (pc_out !== 32'h5C) begin mismatched++; $display("FAIL st_pc[%0d] got %h want 5c", i, pc_out); end
            compared++; if (instr_out !== ALU_B) begin mismatched++; $display("FAIL st_instr[%0d] got %h want %h", i, instr_out, ALU_B); end
        end
        stall = 1'b0;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL st_rel_sel got %b want 0", pc_selector); end
        tick();
        compared++; if (pc_out !== 32'h20) begin mismatched++; $display("FAIL st_resume_pc got %h want 20", pc_out); end
        compared++; if (instr_out !== ALU_A) begin mismatched++; $display("FAIL st_resume_instr got %h want %h", instr_out, ALU_A); end
        compared++; if (stalled !== 1'b0) begin mismatched++; $display("FAIL st_resume_stalled got %b want 0", stalled); end
        compared++; if (redirect_cnt !== 16'h1) begin mismatched++; $display("FAIL st_cnt got %h want 1", redirect_cnt); end
    endtask

    task automatic test_held_jump();
        pc_in = 32'h30; instr_in = JMP40;
        tick();
        pc_in = 32'h34; instr_in = ALU_A; stall = 1'b1;
        #1;
        compared++; if (jmp_pc !== 32'h34) begin mismatched++; $display("FAIL hj_stall_jmp got %h want 34", jmp_pc); end
        tick(); tick();
        compared++; if (redirect_cnt !== 16'h1) begin mismatched++; $display("FAIL hj_stall_cnt got %h want 1", redirect_cnt); end
        compared++; if (instr_out !== JMP40) begin mismatched++; $display("FAIL hj_held_instr got %h want %h", instr_out, JMP40); end
        stall = 1'b0;
        #1;
        compared++; if (pc_selector !== 1'b1) begin mismatched++; $display("FAIL hj_sel got %b want 1", pc_selector); end
        compared++; if (jmp_pc !== 32'h100) begin mismatched++; $display("FAIL hj_target got %h want 100", jmp_pc); end
        tick();
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL hj_bubble got %b want 0", valid_out); end
        compared++; if (redirect_cnt !== 16'h2) begin mismatched++; $display("FAIL hj_cnt got %h want 2", redirect_cnt); end
        pc_in = 32'h100; instr_in = ALU_B;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL hj_once_sel got %b want 0", pc_selector); end
        tick();
        compared++; if (pc_out !== 32'h100) begin mismatched++; $display("FAIL hj_landed_pc got %h want 100", pc_out); end
        compared++; if (redirect_cnt !== 16'h2) begin mismatched++; $display("FAIL hj_once_cnt got %h want 2", redirect_cnt); end
    endtask

    task automatic test_branch_priority();
        pc_in = 32'h40; instr_in = JMP17;
        tick();
        pc_in = 32'h44; instr_in = ALU_A; stall = 1'b1;
        tick();
        compared++; if (stalled !== 1'b1) begin mismatched++; $display("FAIL bp_hold got %b want 1", stalled); end
        ex_branch_taken = 1'b1; ex_branch_pc = 32'h100;
        #1;
        compared++; if (jmp_pc !== 32'h100) begin mismatched++; $display("FAIL bp_jmp got %h want 100", jmp_pc); end
        compared++; if (flush_ex !== 1'b1) begin mismatched++; $display("FAIL bp_flush got %b want 1", flush_ex); end
        compared++; if (pc_selector !== 1'b1) begin mismatched++; $display("FAIL bp_sel got %b want 1", pc_selector); end
        tick();
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL bp_bubble got %b want 0", valid_out); end
        compared++; if (pc_out !== 32'h44) begin mismatched++; $display("FAIL bp_pc got %h want 44", pc_out); end
        compared++; if (stalled !== 1'b0) begin mismatched++; $display("FAIL bp_stalled got %b want 0", stalled); end
        compared++; if (redirect_cnt !== 16'h3) begin mismatched++; $display("FAIL bp_cnt got %h want 3", redirect_cnt); end
        ex_branch_taken = 1'b0; stall = 1'b0;
    endtask

    task automatic test_mid_hold_reset();
        pc_in = 32'h50; instr_in = JMP17;
        tick();
        stall = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL mr_sel got %b want 0", pc_selector); end
        tick();
        compared++; if (stalled !== 1'b0) begin mismatched++; $display("FAIL mr_stalled got %b want 0", stalled); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL mr_valid got %b want 0", valid_out); end
        compared++; if (redirect_cnt !== 16'h0) begin mismatched++; $display("FAIL mr_cnt got %h want 0", redirect_cnt); end
        reset = 1'b1; stall = 1'b0; pc_in = 32'h60; instr_in = ALU_A;
        #1;
        compared++; if (pc_selector !== 1'b0) begin mismatched++; $display("FAIL mr_nojump got %b want 0", pc_selector); end
        tick();
        compared++; if (pc_out !== 32'h60) begin mismatched++; $display("FAIL mr_pc got %h want 60", pc_out); end
    endtask

    task automatic test_saturation();
        ex_branch_taken = 1'b1; ex_branch_pc = 32'h200;
        for (int i = 0; i < 65534; i++) tick();
        compared++; if (redirect_cnt !== 16'hFFFE) begin mismatched++; $display("FAIL sat_preset got %h want fffe", redirect_cnt); end
        tick();
        compared++; if (redirect_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_first got %h want ffff", redirect_cnt); end
        tick(); tick();
        compared++; if (redirect_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold got %h want ffff", redirect_cnt); end
        ex_branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_held_jump();
        test_branch_priority();
        test_mid_hold_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
